// File: rtl/dna_pkg.sv
// Shared nucleotide definitions for the DNA pattern detector slice.
package dna_pkg;

  // One nucleotide symbol on the 2-bit stream.
  typedef logic [1:0] sym_t;

  localparam sym_t SYM_A = 2'b00;
  localparam sym_t SYM_T = 2'b01;
  localparam sym_t SYM_C = 2'b10;
  localparam sym_t SYM_G = 2'b11;

endpackage

// File: rtl/dna_hist_shift.sv
// Symbol history shift register plus the count of valid history entries.
// The shifted-in view is exported so the matcher can look at the window
// the way it will stand after the current edge.
module dna_hist_shift
  import dna_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift,
  input  logic                     clr,
  input  sym_t                     x,
  output sym_t [MAX_LEN-1:0]       hist_nxt,
  output logic [LEN_W-1:0]         fill_nxt,
  output logic [LEN_W-1:0]         fill
);

  sym_t [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // History and depth as they would be if the current symbol is accepted.
  always_comb begin
    hist_d = {hist_q[MAX_LEN-2:0], x};
    fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
  end

  // History moves only on accepted symbols; a clear wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (shift) hist_q <= hist_d;
      if (clr) fill_q <= '0;
      else if (shift) fill_q <= fill_d;
    end
  end

  assign hist_nxt = hist_d;
  assign fill_nxt = fill_d;
  assign fill     = fill_q;

endmodule

// File: rtl/dna_pattern_detector.sv
// Streaming nucleotide pattern detector with programmable pattern, length,
// wildcard mask and overlap mode, plus a saturating match counter.
module dna_pattern_detector
  import dna_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       x,
  input  logic             x_valid,
  input  logic             pat_wr,
  input  logic [IDX_W-1:0] pat_idx,
  input  logic [1:0]       pat_sym,
  input  logic             pat_dc,
  input  logic             cfg_wr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] fill
);

  sym_t [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] dc_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               y_q;
  logic [CNT_W-1:0]   cnt_q;

  sym_t [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill_nxt;
  logic [IDX_W-1:0]   pos;
  logic               cfg_any, shift, all_ok, match, fill_clr;

  // Any configuration write owns the edge: the symbol is dropped and the
  // window restarts. A non-overlapping match also restarts the window.
  assign cfg_any  = pat_wr | cfg_wr;
  assign shift    = x_valid & ~cfg_any;
  assign fill_clr = cfg_any | (match & ~ovl_q);

  dna_hist_shift #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .clr      (fill_clr),
    .x        (x),
    .hist_nxt (hist_nxt),
    .fill_nxt (fill_nxt),
    .fill     (fill)
  );

  // Compare every active slot against the post-shift window; slot 0 is the
  // oldest symbol of the window, so it lines up with hist_nxt[len-1].
  always_comb begin
    all_ok = 1'b1;
    pos    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      pos = IDX_W'(len_q - LEN_W'(i + 1));
      if ((LEN_W'(i) < len_q) && !dc_q[i] && (pat_q[i] != hist_nxt[pos]))
        all_ok = 1'b0;
    end
  end

  assign match = shift && (len_q != '0) && (fill_nxt >= len_q) && all_ok;

  // Pattern slots and window configuration; length is clamped to MAX_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= {MAX_LEN{SYM_A}};
      dc_q  <= '0;
      len_q <= '0;
      ovl_q <= 1'b1;
    end else begin
      if (pat_wr && (int'(pat_idx) < MAX_LEN)) begin
        pat_q[pat_idx] <= pat_sym;
        dc_q[pat_idx]  <= pat_dc;
      end
      if (cfg_wr) begin
        len_q <= (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
        ovl_q <= cfg_ovl;
      end
    end
  end

  // Registered match pulse and saturating counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      y_q <= match;
      if (cnt_clr) cnt_q <= '0;
      else if (match && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_dna_pattern_detector.sv
// Self-checking bench for dna_pattern_detector: directed scenarios followed
// by a randomized stream compared against a queue-based reference model.
module tb_dna_pattern_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  x = '0;
  logic        x_valid = 1'b0;
  logic        pat_wr = 1'b0;
  logic [2:0]  pat_idx = '0;
  logic [1:0]  pat_sym = '0;
  logic        pat_dc = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_ovl = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        y, y2;
  logic [15:0] match_cnt;
  logic [1:0]  cnt2;
  logic [3:0]  fill, fill2;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [1:0] mPat [8];
  logic       mDc  [8];
  logic [1:0] mHist [$];
  int         mLen, mFill, mCnt, mCnt2;
  logic       mOvl, expY;

  dna_pattern_detector #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_sym(pat_sym), .pat_dc(pat_dc),
    .cfg_wr(cfg_wr), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y), .match_cnt(match_cnt), .fill(fill)
  );

  dna_pattern_detector #(.MAX_LEN(8), .CNT_W(2)) dutNarrow (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
    .pat_wr(pat_wr), .pat_idx(pat_idx), .pat_sym(pat_sym), .pat_dc(pat_dc),
    .cfg_wr(cfg_wr), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(cnt2), .fill(fill2)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] symOf(input byte c);
    case (c)
      "T": return 2'b01;
      "C": return 2'b10;
      "G": return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 8; k++) begin
      mPat[k] = 2'b00;
      mDc[k]  = 1'b0;
    end
    mHist.delete();
    mLen = 0; mFill = 0; mCnt = 0; mCnt2 = 0;
    mOvl = 1'b1; expY = 1'b0;
  endfunction

  // The last mLen accepted symbols, oldest first, against the pattern.
  function automatic logic modelMatch();
    if (mLen == 0 || mFill < mLen) return 1'b0;
    for (int k = 0; k < mLen; k++)
      if (!mDc[k] && mPat[k] != mHist[mHist.size() - mLen + k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelStep();
    expY = 1'b0;
    if (pat_wr || cfg_wr) begin
      if (pat_wr) begin
        mPat[pat_idx] = pat_sym;
        mDc[pat_idx]  = pat_dc;
      end
      if (cfg_wr) begin
        mLen = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
        mOvl = cfg_ovl;
      end
      mFill = 0;
    end else if (x_valid) begin
      mHist.push_back(x);
      if (mHist.size() > 8) void'(mHist.pop_front());
      if (mFill < 8) mFill++;
      if (modelMatch()) begin
        expY = 1'b1;
        if (!mOvl) mFill = 0;
      end
    end
    if (cnt_clr) begin
      mCnt = 0; mCnt2 = 0;
    end else if (expY) begin
      if (mCnt < 65535) mCnt++;
      if (mCnt2 < 3) mCnt2++;
    end
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("y", 32'(y), 32'(expY));
    checkValue("match_cnt", 32'(match_cnt), 32'(mCnt));
    checkValue("fill", 32'(fill), 32'(mFill));
    checkValue("match_cnt_narrow", 32'(cnt2), 32'(mCnt2));
  endtask

  task automatic applyStimulus(input logic xv, input logic [1:0] xs,
                               input logic pw, input logic [2:0] pi,
                               input logic [1:0] ps, input logic pd,
                               input logic cw, input logic [3:0] cl,
                               input logic co, input logic cc);
    x_valid = xv; x = xs;
    pat_wr = pw; pat_idx = pi; pat_sym = ps; pat_dc = pd;
    cfg_wr = cw; cfg_len = cl; cfg_ovl = co; cnt_clr = cc;
    modelStep();
    @(posedge clk);
    #1;
    x_valid = 1'b0; pat_wr = 1'b0; cfg_wr = 1'b0; cnt_clr = 1'b0;
    checkOutput();
  endtask

  task automatic sendSym(input logic [1:0] s);
    applyStimulus(1'b1, s, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic writePat(input logic [2:0] i, input logic [1:0] s, input logic dc);
    applyStimulus(1'b0, 2'd0, 1'b1, i, s, dc, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic writeCfg(input logic [3:0] len, input logic ovl);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, len, ovl, 1'b0);
  endtask

  task automatic clearCnt();
    applyStimulus(1'b0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic loadPattern(input string p, input logic [3:0] len, input logic ovl);
    for (int i = 0; i < p.len(); i++) writePat(3'(i), symOf(p[i]), 1'b0);
    writeCfg(len, ovl);
  endtask

  task automatic runStream(input string s, input logic [15:0] pulses);
    for (int i = 0; i < s.len(); i++) begin
      sendSym(symOf(s[i]));
      nChecks++;
      assert (y === pulses[i]) else begin
        nFails++;
        $error("[TB] FAIL pulse[%0d] of %s: observed %0b expected %0b", i, s, y, pulses[i]);
      end
    end
  endtask

  initial begin
    logic xv, pw, pd, cw, co, cc;
    logic [1:0] xs, ps;
    logic [2:0] pi;
    logic [3:0] cl;
    int r;

    // Reset state
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    $display("[TB] reset released");

    // Test 1: TTCG, overlapping
    loadPattern("TTCG", 4'd4, 1'b1);
    clearCnt();
    runStream("CGATTCGCCATTCGAC", 16'h2040);
    checkValue("t1_cnt", 32'(match_cnt), 32'd2);

    // Test 2: CC with and without overlap
    loadPattern("CC", 4'd2, 1'b1);
    clearCnt();
    runStream("CCCC", 16'h000E);
    checkValue("t2_cnt_ovl", 32'(match_cnt), 32'd3);
    writeCfg(4'd2, 1'b0);
    clearCnt();
    runStream("CCCC", 16'h000A);
    checkValue("t2_cnt_noovl", 32'(match_cnt), 32'd2);

    // Test 3: C followed by wildcard
    writePat(3'd0, 2'b10, 1'b0);
    writePat(3'd1, 2'b00, 1'b1);
    writeCfg(4'd2, 1'b1);
    clearCnt();
    runStream("CGATTCGCCATTCGAC", 16'h2342);
    checkValue("t3_cnt", 32'(match_cnt), 32'd5);

    // Test 4: saturation of the narrow counter, then clear against a match
    writePat(3'd0, 2'b00, 1'b0);
    writeCfg(4'd1, 1'b1);
    clearCnt();
    for (int i = 0; i < 6; i++) begin
      sendSym(2'b00);
      checkValue("t4_cnt_narrow", 32'(cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    applyStimulus(1'b1, 2'b00, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkValue("t4_clr_y", 32'(y), 32'd1);
    checkValue("t4_clr_cnt", 32'(match_cnt), 32'd0);
    checkValue("t4_clr_cnt_narrow", 32'(cnt2), 32'd0);

    // Test 5: reset in the middle of a match window
    loadPattern("TTCG", 4'd4, 1'b1);
    clearCnt();
    runStream("CGATTC", 16'h0000);
    rst = 1'b1;
    #1;
    modelReset();
    checkValue("t5_rst_y", 32'(y), 32'd0);
    checkValue("t5_rst_fill", 32'(fill), 32'd0);
    checkValue("t5_rst_cnt", 32'(match_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runStream("AA", 16'h0000);
    loadPattern("TTCG", 4'd4, 1'b1);
    runStream("GCCATTCGAC", 16'h0080);
    checkValue("t5_cnt", 32'(match_cnt), 32'd1);

    // Test 6: configuration write drops a same-edge symbol
    runStream("TTC", 16'h0000);
    applyStimulus(1'b1, 2'b11, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
    checkValue("t6_drop_y", 32'(y), 32'd0);
    checkValue("t6_drop_fill", 32'(fill), 32'd0);
    runStream("G", 16'h0000);
    checkValue("t6_after_fill", 32'(fill), 32'd1);

    // Pattern and config writes on one edge both land
    applyStimulus(1'b0, 2'd0, 1'b1, 3'd3, 2'b11, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    runStream("TTCGTTCG", 16'h0088);

    // Length clamp: all-wildcard pattern with a requested length of 15
    for (int i = 0; i < 8; i++) writePat(3'(i), 2'b00, 1'b1);
    writeCfg(4'd15, 1'b1);
    runStream("ATCGATCGAT", 16'h0380);
    checkValue("t6_clamp_fill", 32'(fill), 32'd8);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r  = $urandom_range(0, 99);
      xv = ($urandom_range(0, 99) < 85);
      xs = 2'($urandom_range(0, 3));
      pw = (r < 5);
      cw = (r >= 3 && r < 8);
      cc = (r >= 8 && r < 11);
      pi = 3'($urandom_range(0, 7));
      ps = 2'($urandom_range(0, 3));
      pd = ($urandom_range(0, 2) == 0);
      cl = 4'($urandom_range(0, 15));
      co = 1'($urandom_range(0, 1));
      applyStimulus(xv, xs, pw, pi, ps, pd, cw, cl, co, cc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
